// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multicycle main control unit: FSM state
//   encodings, supported opcodes and the datapath select codes driven by
//   mc_main_control.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // ALUOp codes to ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on mem_ready.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer
//   Counts consecutive cycles spent waiting for memory and flags when the
//   MEM_TIMEOUT-th consecutive waiting cycle is in progress.
//   Ports:
//     clk      - clock
//     rst_n    - synchronous active-low reset
//     waiting  - memory state with mem_ready low this cycle
//     clear    - state is changing (or timeout taken); restart the count
//     expired  - this cycle is the MEM_TIMEOUT-th consecutive waiting cycle
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);
    import mc_ctrl_pkg::*;

    logic [7:0] count_q;

    // count_q holds the number of earlier waiting cycles, so the current
    // cycle is number count_q+1.
    assign expired = waiting && (count_q == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear || !waiting) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control
//   Moore main control FSM for a multicycle MIPS-style datapath with
//   memory-ready handshaking and a memory wait timeout.
//   Ports:
//     clk, rst_n            - clock, synchronous active-low reset
//     opcode[5:0]           - IR[31:26], used in DECODE and MEMADR
//     mem_ready             - memory completes the access this cycle
//     PCWrite..ALUSrcA      - datapath strobes/selects
//     ALUSrcB, ALUOp,
//     PCSource [1:0]        - datapath select codes
//     illegal_op            - pulse: unsupported opcode in DECODE
//     mem_err               - pulse: memory wait timed out
//     state[3:0]            - current state (debug)
module mc_main_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);
    import mc_ctrl_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   released_q;
    logic   waiting;
    logic   wait_clear;
    logic   expired;

    assign state   = state_q;
    assign waiting = is_mem_wait_state(state_q) && !mem_ready;
    // The timer must restart on every state change, and also on a FETCH
    // timeout, where the state itself does not change.
    assign wait_clear = (state_d != state_q) || expired;
    assign mem_err    = expired;

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clear   (wait_clear),
        .expired (expired)
    );

    // IDLE is held for one cycle after the edge that first samples rst_n
    // high, so the first FETCH lands two edges after reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            released_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_op  = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;

        case (state_q)
            ST_IDLE: begin
                if (released_q) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
                // On timeout the fetch is simply re-issued (stay in FETCH).
            end

            ST_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (opcode)
                    OP_R:         state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d    = ST_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end

            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end

            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (expired) begin
                    state_d = ST_FETCH;
                end
            end

            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready || expired) begin
                    state_d = ST_FETCH;
                end
            end

            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                ALUOp   = ALUOP_FUNCT;
                state_d = ST_RWB;
            end

            ST_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_d     = ST_FETCH;
            end

            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                state_d  = ST_FETCH;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
